// File: rtl/coef_fc_pkg.sv
// Shared types and helpers for the coefficient flow-control link.
// Used by the transmit side and its coefficient buffer.
package coef_fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_DC,
        S_AC,
        S_GAP,
        S_DONE
    } tx_state_e;

    localparam int AC_LEN_DEFAULT = 15;

    function automatic int cnt_w(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/coef_buf.sv
// Coefficient block buffer: entry 0 holds DC, 1..DEPTH-1 hold AC.
// Single write port, asynchronous read port.
module coef_buf #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/coef_block_tx.sv
// Transmit side of the coefficient flow-control link: serialises one
// buffered block as DC word, AC run, gap, counting units like the receiver.
module coef_block_tx
    import coef_fc_pkg::*;
#(
    parameter int MAX_COUNT  = 24,
    parameter int DATA_WIDTH = 12,
    parameter int AC_LEN     = AC_LEN_DEFAULT
) (
    input  logic                            clk,
    input  logic                            RESET,
    input  logic                            WR_EN,
    input  logic [$clog2(AC_LEN+1)-1:0]     WR_ADDR,
    input  logic [DATA_WIDTH-1:0]           WR_DATA,
    input  logic                            START,
    input  logic                            HAS_DC,
    output logic                            READY,
    output logic                            ERR,
    input  logic                            inter_flag_valid,
    output logic                            VALIDO,
    output logic                            DC,
    output logic [DATA_WIDTH-1:0]           DATAO,
    output logic [cnt_w(MAX_COUNT)-1:0]     UNIT_COUNT,
    output logic                            DONE
);

    localparam int AW = $clog2(AC_LEN + 1);
    localparam int CW = cnt_w(MAX_COUNT);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
    localparam logic [AW-1:0] LAST  = AW'(AC_LEN);

    tx_state_e             state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d, rd_idx;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc, rem, need;
    logic                  vld_q, vld_d, dc_q, dc_d;
    logic                  rdy_q, err_q, err_d, done_q;
    logic [DATA_WIDTH-1:0] data_q, data_d, rd_data;

    coef_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (AC_LEN + 1)
    ) u_buf (
        .clk    (clk),
        .we_i   (WR_EN && rdy_q),
        .waddr_i(WR_ADDR),
        .wdata_i(WR_DATA),
        .raddr_i(rd_idx),
        .rdata_o(rd_data)
    );

    assign cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + CW'(1);
    assign rem     = MAX_C - cnt_q;
    assign need    = HAS_DC ? CW'(2) : CW'(1);

    // Next state, word index and unit count; all frozen while the qualifier is low.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (inter_flag_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        if (rem >= need) begin
                            state_d = HAS_DC ? S_DC : S_AC;
                            idx_d   = AW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_DC: begin
                    cnt_d   = cnt_inc;
                    state_d = S_AC;
                end
                S_AC: begin
                    if (idx_q == LAST) begin
                        state_d = S_GAP;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
                S_GAP: begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == MAX_C) ? S_DONE : IDLE;
                end
                S_DONE: state_d = S_DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Word to present in the next cycle, looked up from the next state.
    always_comb begin
        rd_idx = (state_d == S_DC) ? '0 : idx_d;
        vld_d  = (state_d == S_DC) || (state_d == S_AC);
        dc_d   = (state_d == S_DC);
        data_d = vld_d ? rd_data : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            dc_q    <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
            rdy_q   <= (state_d == IDLE);
            err_q   <= err_d;
            done_q  <= (cnt_d == MAX_C);
        end
    end

    // The receiver ignores frozen cycles, so the held word is blanked while
    // the qualifier is low and reappears unchanged when it returns.
    assign VALIDO     = vld_q & inter_flag_valid;
    assign DC         = dc_q & inter_flag_valid;
    assign DATAO      = inter_flag_valid ? data_q : '0;
    assign READY      = rdy_q;
    assign ERR        = err_q;
    assign UNIT_COUNT = cnt_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_coef_block_tx.sv
// Directed bench for coef_block_tx: framing, freeze, unit limit, reset abort,
// and a loop-back against a behavioural receiver gate.
module tb_coef_block_tx;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_a, rst_b, wr_en, ifv;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start_a, hasdc_a, start_b, hasdc_b;
    logic          rdy_a, err_a, vld_a, dc_a, done_a;
    logic          rdy_b, err_b, vld_b, dc_b, done_b;
    logic [DW-1:0] dat_a, dat_b;
    logic [5:0]    cnt_a;
    logic [2:0]    cnt_b;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    coef_block_tx #(.MAX_COUNT(24), .DATA_WIDTH(DW), .AC_LEN(15)) dut_a (
        .clk(clk), .RESET(rst_a), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_DATA(wr_data), .START(start_a), .HAS_DC(hasdc_a),
        .READY(rdy_a), .ERR(err_a), .inter_flag_valid(ifv),
        .VALIDO(vld_a), .DC(dc_a), .DATAO(dat_a),
        .UNIT_COUNT(cnt_a), .DONE(done_a)
    );

    coef_block_tx #(.MAX_COUNT(3), .DATA_WIDTH(DW), .AC_LEN(15)) dut_b (
        .clk(clk), .RESET(rst_b), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_DATA(wr_data), .START(start_b), .HAS_DC(hasdc_b),
        .READY(rdy_b), .ERR(err_b), .inter_flag_valid(ifv),
        .VALIDO(vld_b), .DC(dc_b), .DATAO(dat_b),
        .UNIT_COUNT(cnt_b), .DONE(done_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a = 1; rst_b = 1; ifv = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        start_a = 0; hasdc_a = 0; start_b = 0; hasdc_b = 0;
        tick; tick;
        rst_a = 0; rst_b = 0;
        checks++;
        if ({rdy_a, vld_a, dc_a, err_a, done_a} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags_a got %b want 10000", {rdy_a, vld_a, dc_a, err_a, done_a});
        end
        checks++;
        if (dat_a !== 12'h0 || cnt_a !== 6'd0) begin
            errors++; $display("FAIL reset_data_cnt_a got %h/%0d want 0/0", dat_a, cnt_a);
        end
        checks++;
        if ({rdy_b, vld_b, err_b, done_b} !== 4'b1000 || cnt_b !== 3'd0) begin
            errors++; $display("FAIL reset_b got %b cnt %0d want 1000 cnt 0", {rdy_b, vld_b, err_b, done_b}, cnt_b);
        end
    endtask

    task automatic write_ramp;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 12'h100 + 12'(i);
            tick;
        end
        wr_en = 0;
    endtask

    task automatic test_dc_block;
        start_a = 1; hasdc_a = 1;
        tick;
        start_a = 0;
        checks++;
        if ({vld_a, dc_a, rdy_a} !== 3'b110 || dat_a !== 12'h100 || cnt_a !== 6'd0) begin
            errors++; $display("FAIL dc_word got v/dc/rdy %b data %h cnt %0d want 110 100 0", {vld_a, dc_a, rdy_a}, dat_a, cnt_a);
        end
        for (int i = 1; i < 16; i++) begin
            tick;
            checks++;
            if ({vld_a, dc_a} !== 2'b10 || dat_a !== 12'h100 + 12'(i)) begin
                errors++; $display("FAIL dc_blk_ac%0d got %b %h want 10 %h", i, {vld_a, dc_a}, dat_a, 12'h100 + 12'(i));
            end
            if (i == 1) begin
                checks++;
                if (cnt_a !== 6'd1) begin
                    errors++; $display("FAIL cnt_after_dc got %0d want 1", cnt_a);
                end
            end
        end
        tick;
        checks++;
        if ({vld_a, dc_a, rdy_a} !== 3'b000 || dat_a !== 12'h0 || cnt_a !== 6'd1) begin
            errors++; $display("FAIL dc_blk_gap got %b %h cnt %0d want 000 0 1", {vld_a, dc_a, rdy_a}, dat_a, cnt_a);
        end
        tick;
        checks++;
        if (rdy_a !== 1'b1 || cnt_a !== 6'd2) begin
            errors++; $display("FAIL dc_blk_end got rdy %b cnt %0d want 1 2", rdy_a, cnt_a);
        end
    endtask

    task automatic test_ac_block;
        start_a = 1; hasdc_a = 0;
        for (int i = 1; i < 16; i++) begin
            tick;
            start_a = 0;
            checks++;
            if ({vld_a, dc_a} !== 2'b10 || dat_a !== 12'h100 + 12'(i)) begin
                errors++; $display("FAIL ac_blk_%0d got %b %h want 10 %h", i, {vld_a, dc_a}, dat_a, 12'h100 + 12'(i));
            end
        end
        tick;
        checks++;
        if ({vld_a, dc_a} !== 2'b00 || cnt_a !== 6'd2) begin
            errors++; $display("FAIL ac_blk_gap got %b cnt %0d want 00 2", {vld_a, dc_a}, cnt_a);
        end
        tick;
        checks++;
        if (rdy_a !== 1'b1 || cnt_a !== 6'd3) begin
            errors++; $display("FAIL ac_blk_end got rdy %b cnt %0d want 1 3", rdy_a, cnt_a);
        end
    endtask

    task automatic test_freeze;
        start_a = 1; hasdc_a = 0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            start_a = 0;
        end
        checks++;
        if (vld_a !== 1'b1 || dat_a !== 12'h105) begin
            errors++; $display("FAIL frz_pre got %b %h want 1 105", vld_a, dat_a);
        end
        ifv = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({vld_a, dc_a} !== 2'b00 || dat_a !== 12'h0 || cnt_a !== 6'd3) begin
                errors++; $display("FAIL frz_hold%0d got %b %h cnt %0d want 00 0 3", k, {vld_a, dc_a}, dat_a, cnt_a);
            end
            tick;
        end
        ifv = 1;
        #1;
        checks++;
        if (vld_a !== 1'b1 || dat_a !== 12'h105) begin
            errors++; $display("FAIL frz_resume got %b %h want 1 105", vld_a, dat_a);
        end
        for (int i = 6; i < 16; i++) begin
            tick;
            checks++;
            if (vld_a !== 1'b1 || dat_a !== 12'h100 + 12'(i)) begin
                errors++; $display("FAIL frz_ac%0d got %b %h want 1 %h", i, vld_a, dat_a, 12'h100 + 12'(i));
            end
        end
        tick; tick;
        checks++;
        if (rdy_a !== 1'b1 || cnt_a !== 6'd4) begin
            errors++; $display("FAIL frz_end got rdy %b cnt %0d want 1 4", rdy_a, cnt_a);
        end
    endtask

    task automatic test_max_count;
        start_b = 1; hasdc_b = 1;
        tick;
        start_b = 0;
        repeat (17) tick;
        checks++;
        if (rdy_b !== 1'b1 || cnt_b !== 3'd2 || done_b !== 1'b0) begin
            errors++; $display("FAIL max_first got rdy %b cnt %0d done %b want 1 2 0", rdy_b, cnt_b, done_b);
        end
        start_b = 1; hasdc_b = 1;
        tick;
        start_b = 0;
        checks++;
        if ({err_b, rdy_b, vld_b} !== 3'b110) begin
            errors++; $display("FAIL max_refuse got err/rdy/v %b want 110", {err_b, rdy_b, vld_b});
        end
        tick;
        checks++;
        if ({err_b, rdy_b} !== 2'b01) begin
            errors++; $display("FAIL max_err_pulse got err/rdy %b want 01", {err_b, rdy_b});
        end
        start_b = 1; hasdc_b = 0;
        tick;
        start_b = 0;
        checks++;
        if ({vld_b, dc_b} !== 2'b10 || dat_b !== 12'h101) begin
            errors++; $display("FAIL max_ac_send got %b %h want 10 101", {vld_b, dc_b}, dat_b);
        end
        repeat (16) tick;
        checks++;
        if ({done_b, rdy_b, vld_b} !== 3'b100 || cnt_b !== 3'd3) begin
            errors++; $display("FAIL max_done got done/rdy/v %b cnt %0d want 100 3", {done_b, rdy_b, vld_b}, cnt_b);
        end
        start_b = 1;
        tick;
        start_b = 0;
        checks++;
        if ({err_b, vld_b, done_b} !== 3'b001) begin
            errors++; $display("FAIL max_ignore got err/v/done %b want 001", {err_b, vld_b, done_b});
        end
    endtask

    task automatic test_reset_mid;
        start_a = 1; hasdc_a = 1;
        tick;
        start_a = 0;
        repeat (8) tick;
        checks++;
        if (dat_a !== 12'h108) begin
            errors++; $display("FAIL rstmid_pre got %h want 108", dat_a);
        end
        rst_a = 1;
        tick;
        rst_a = 0;
        checks++;
        if ({rdy_a, vld_a, dc_a, err_a, done_a} !== 5'b10000 || dat_a !== 12'h0 || cnt_a !== 6'd0) begin
            errors++; $display("FAIL rstmid got %b %h cnt %0d want 10000 0 0", {rdy_a, vld_a, dc_a, err_a, done_a}, dat_a, cnt_a);
        end
    endtask

    task automatic test_loopback;
        logic [DW-1:0] bm [16];
        logic [DW:0]   q [$];
        logic [DW:0]   w;
        int            rx = 0;
        bit            rx_ac = 0;
        bit            err_exp = 0;
        int            cyc = 0;
        for (int i = 0; i < 16; i++) begin
            bm[i] = DW'($urandom);
            wr_en = 1; wr_addr = 4'(i); wr_data = bm[i];
            tick;
        end
        wr_en = 0;
        while (!done_a && cyc < 4000) begin
            ifv = ($urandom_range(0, 3) != 0);
            hasdc_a = 1'($urandom_range(0, 1));
            start_a = rdy_a;
            #1;
            checks++;
            if (err_a !== err_exp) begin
                errors++; $display("FAIL lb_err cyc %0d got %b want %b", cyc, err_a, err_exp);
            end
            err_exp = 0;
            if (!ifv) begin
                checks++;
                if ({vld_a, dc_a} !== 2'b00 || dat_a !== 12'h0) begin
                    errors++; $display("FAIL lb_frozen cyc %0d got %b %h want 00 0", cyc, {vld_a, dc_a}, dat_a);
                end
            end else begin
                if (vld_a) begin
                    checks++;
                    if (rx >= 24) begin
                        errors++; $display("FAIL lb_enable cyc %0d rx count %0d want below 24", cyc, rx);
                    end
                    checks++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL lb_extra cyc %0d got %h want no word", cyc, dat_a);
                    end else begin
                        w = q.pop_front();
                        if ({dc_a, dat_a} !== w) begin
                            errors++; $display("FAIL lb_word cyc %0d got %h want %h", cyc, {dc_a, dat_a}, w);
                        end
                    end
                    if (dc_a) rx++;
                    else rx_ac = 1;
                end else if (rx_ac) begin
                    rx++;
                    rx_ac = 0;
                end
                if (start_a && rdy_a) begin
                    if (24 - rx >= (hasdc_a ? 2 : 1)) begin
                        if (hasdc_a) q.push_back({1'b1, bm[0]});
                        for (int k = 1; k < 16; k++) q.push_back({1'b0, bm[k]});
                    end else begin
                        err_exp = 1;
                    end
                end
            end
            tick;
            cyc++;
        end
        start_a = 0;
        ifv = 1;
        checks++;
        if (done_a !== 1'b1 || cnt_a !== 6'd24 || rx != 24) begin
            errors++; $display("FAIL lb_final got done %b cnt %0d rx %0d want 1 24 24", done_a, cnt_a, rx);
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL lb_pending got %0d words want 0", q.size());
        end
    endtask

    initial begin
        test_reset;
        write_ramp;
        test_dc_block;
        test_ac_block;
        test_freeze;
        test_max_count;
        test_reset_mid;
        test_loopback;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
